// File: rtl/pc_stack_pkg.sv
// Shared types and helpers for the ez8 program-counter controller.
package pc_stack_pkg;

  // Controller state. STOPPED and ERROR are left only through reset.
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STOPPED = 2'd1,
    ST_ERROR   = 2'd2
  } pc_state_e;

  // Width of a stack occupancy counter that must be able to hold 0..depth.
  function automatic int stack_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_stack_ctrl_call_stack.sv
// call_stack: register-array LIFO holding return addresses.
// The top entry is readable combinationally. The caller never issues push
// and pop in the same cycle; a push when full or a pop when empty is dropped.
module call_stack
  import pc_stack_pkg::*;
#(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 8,
  localparam int LW    = stack_lvl_w(DEPTH),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    level_q;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  // The next free slot is indexed by the occupancy; the top sits one below it.
  assign wr_idx  = level_q[IW-1:0];
  assign rd_idx  = IW'(level_q - LW'(1));
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign top_o   = empty_o ? '0 : mem_q[rd_idx];

  // Storage write: entries need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  // Occupancy counter with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= '0;
    end else if (push_i && !full_o) begin
      level_q <= level_q + LW'(1);
    end else if (pop_i && !empty_o) begin
      level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/pc_stack_ctrl.sv
// pc_stack_ctrl: program-counter controller for the ez8 fetch stage.
// Drives the registered-read instruction memory address and a kill flag that
// squashes the instruction in decode after taken branches, returns and skips.
// Optional feature macro: PC_IRQ_EN adds the irq port and interrupt entry.
// Handshake: there is no valid/ready pair; pause=1 freezes every register,
// and control inputs are honoured only while running, unpaused and not killed.
module pc_stack_ctrl
  import pc_stack_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 12,
  parameter  int STACK_DEPTH = 8,
  parameter  int IRQ_VECTOR  = 1,
  localparam int LVL_W       = stack_lvl_w(STACK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic [ADDR_WIDTH-1:0] goto_addr,
  input  logic                  goto,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  skip,
`ifdef PC_IRQ_EN
  input  logic                  irq,
`endif
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  kill,
  output logic                  stopped,
  output logic                  error,
  output logic [LVL_W-1:0]      stack_level,
  output pc_state_e             dbg_state
);

  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] dec_pc_q, dec_pc_d;
  logic                  kill_q, kill_d;

  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] push_data;
  logic [ADDR_WIDTH-1:0] top;
  logic [LVL_W-1:0]      level;
  logic                  full, empty;
  logic                  advance, act;

`ifdef PC_IRQ_EN
  localparam logic [ADDR_WIDTH-1:0] IRQ_VEC = ADDR_WIDTH'(IRQ_VECTOR);
  logic                  in_irq_q, in_irq_d;
  logic [LVL_W-1:0]      irq_level_q, irq_level_d;
`endif

  call_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .top_o   (top),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Next-state logic: priority ret > call > goto > skip > (irq) > sequential.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dec_pc_d  = dec_pc_q;
    kill_d    = kill_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = dec_pc_q + ADDR_WIDTH'(1);
`ifdef PC_IRQ_EN
    in_irq_d    = in_irq_q;
    irq_level_d = irq_level_q;
`endif
    advance = (state_q == ST_RUN) && !pause;
    act     = advance && !kill_q;

    if (state_q != ST_RUN) begin
      kill_d = 1'b1;
    end else if (advance) begin
      dec_pc_d = pc_q;
      pc_d     = pc_q + ADDR_WIDTH'(1);
      kill_d   = 1'b0;
      if (act) begin
        if (ret) begin
          kill_d = 1'b1;
          if (empty) begin
            state_d = ST_ERROR;
            pc_d    = pc_q;
          end else begin
            pc_d = top;
            pop  = 1'b1;
`ifdef PC_IRQ_EN
            if (in_irq_q && ((level - LVL_W'(1)) == irq_level_q)) begin
              in_irq_d = 1'b0;
            end
`endif
          end
        end else if (call && full) begin
          kill_d  = 1'b1;
          state_d = ST_ERROR;
          pc_d    = pc_q;
        end else if (call || goto) begin
          // A call pushes its return address and then behaves as a goto.
          kill_d = 1'b1;
          push   = call;
          if (goto_addr == dec_pc_q) begin
            state_d = ST_STOPPED;
            pc_d    = pc_q;
          end else begin
            pc_d = goto_addr;
          end
        end else if (skip) begin
          kill_d = 1'b1;
`ifdef PC_IRQ_EN
        end else if (irq && !in_irq_q) begin
          // The squashed decode instruction is re-executed on return.
          kill_d = 1'b1;
          if (full) begin
            state_d = ST_ERROR;
            pc_d    = pc_q;
          end else begin
            push        = 1'b1;
            push_data   = dec_pc_q;
            pc_d        = IRQ_VEC;
            in_irq_d    = 1'b1;
            irq_level_d = level;
          end
`endif
        end
      end
    end
  end

  // State register with synchronous active-low reset overriding pause.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      dec_pc_q <= '0;
      kill_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      dec_pc_q <= dec_pc_d;
      kill_q   <= kill_d;
    end
  end

`ifdef PC_IRQ_EN
  // Interrupt bookkeeping: nesting is blocked while a handler is active.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_irq_q    <= 1'b0;
      irq_level_q <= '0;
    end else begin
      in_irq_q    <= in_irq_d;
      irq_level_q <= irq_level_d;
    end
  end
`endif

  assign pc_out      = pc_q;
  assign kill        = kill_q;
  assign stopped     = (state_q != ST_RUN);
  assign error       = (state_q == ST_ERROR);
  assign stack_level = level;
  assign dbg_state   = state_q;

endmodule

// File: doc/pc_stack_ctrl.md
Name: pc_stack_ctrl

Overview:
Parametrised program-counter controller for the ez8 fetch stage, driving the registered-read instruction memory.
- Supports goto, call, ret and skip.
- Call stack depth and address width are configurable.
- Stack overflow and underflow are trapped and reported.
- Halts on a self-loop goto.
- Sits between instruction decode and the instruction-memory read address; its kill output squashes the instruction currently in decode.

Parameters:
ADDR_WIDTH, 12, PC and goto address width
STACK_DEPTH, 8, call-stack entries (>=2)
IRQ_VECTOR, 1, interrupt entry address (used only with PC_IRQ_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low; state resets on a clk edge while reset==0
pause  input  1  freezes all state when 1
goto_addr  input  ADDR_WIDTH  branch/call target (decode instruction field)
goto  input  1  decode instruction is goto or call
call  input  1  decode instruction is call (asserted together with goto)
ret  input  1  decode instruction is return
skip  input  1  squash the instruction now in decode
irq  input  1  level interrupt request (present only with PC_IRQ_EN)
pc_out  output  ADDR_WIDTH  instruction-memory read address
kill  output  1  instruction in decode is invalid; downstream must suppress its writes
stopped  output  1  controller halted
error  output  1  stack overflow/underflow trapped (sticky)
stack_level  output  clog2(STACK_DEPTH+1)  current stack occupancy

Behaviour:
- Reset (reset==0 at clk edge):
  - pc_out=0, kill=1, stopped=0, error=0, stack_level=0.
  - Internal dec_pc=0; state=RUN.
  - Takes effect mid-operation, overriding everything including pause.
- dec_pc tracks the address of the instruction in decode: dec_pc <= pc_out on every advancing cycle.
- Control inputs are acted on only when state==RUN && !pause && !kill. Otherwise they are ignored: they come from a squashed or stale instruction.
- pause=1: pc_out, dec_pc, kill, stack and state all hold.
- Priority when several inputs are high: ret > call > goto > skip > sequential.
- Sequential: pc_out <= pc_out+1 mod 2^ADDR_WIDTH; kill <= 0.
- goto:
  - If goto_addr==dec_pc, then state <= STOPPED and stopped=1 from the next cycle.
  - Otherwise pc_out <= goto_addr and kill <= 1 for exactly one cycle.
- call:
  - Pushes dec_pc+1, then behaves as goto.
  - If stack_level==STACK_DEPTH: no push, state <= ERROR, error=1, stopped=1.
- ret:
  - pc_out <= top of stack, pop, kill <= 1.
  - If stack_level==0: state <= ERROR, error=1, stopped=1.
- skip: pc_out <= pc_out+1, kill <= 1 for one cycle.
- States:
  - RUN -> STOPPED on self-goto.
  - RUN -> ERROR on overflow/underflow.
  - STOPPED and ERROR are terminal until reset.
  - In STOPPED/ERROR, pc_out holds and kill=1.
- Latency: a taken branch reaches pc_out 1 cycle after decode. Target instruction is in decode 2 cycles after the branch was in decode. One squashed slot per taken branch/skip.
- Stack storage: register array, top entry readable combinationally.

Optional Feature:
PC_IRQ_EN
- Defined:
  - Adds the irq port and internal flags in_irq and irq_level.
  - Interrupt is taken when irq=1 && !in_irq && RUN && !pause && !kill, and no control input is active.
  - On take: push dec_pc (the squashed instruction is re-executed on return), pc_out <= IRQ_VECTOR, kill <= 1, in_irq <= 1, irq_level <= stack_level.
  - A full stack on take triggers ERROR.
  - A ret that pops the stack to irq_level clears in_irq.
- Undefined: no irq port, no interrupt logic; behaviour identical to the above otherwise.

Decomposition:
- Package pc_stack_pkg holds:
  - state enum RUN/STOPPED/ERROR;
  - a helper constant for stack_level width, clog2(STACK_DEPTH+1).
- One sub-module: call_stack.
  - Parametrised LIFO with push, pop, top, level, full and empty.
  - Push and pop are never issued in the same cycle.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> pc_out=0,1,2,3 on successive cycles; kill=1 only in the first cycle.
- goto 0x040 decoded at dec_pc=0x005 -> next pc_out=0x040, kill=1 one cycle, then pc_out=0x041 and kill=0.
- call 0x100 at dec_pc=0x010, then ret at 0x100 -> stack_level 1 then 0; pc_out returns to 0x011; one killed slot after each.
- 9 nested calls with STACK_DEPTH=8 -> 9th call gives error=1, stopped=1, stack_level stays 8. Separately, ret at empty stack -> error=1.
- goto_addr==dec_pc=0x020 -> stopped=1, error=0, pc_out frozen; pause toggling and later inputs are ignored.
- Assert pause during a taken goto -> goto acted on only after pause drops. With PC_IRQ_EN, irq at dec_pc=0x030 -> pc_out=IRQ_VECTOR, and the handler's ret resumes at 0x030 with in_irq cleared.
